// File: rtl/sdram_write.sv
// rtl/sdram_write.sv - SDRAM write-burst engine: ACTIVE, full-page WRITE, data stream, BURST STOP, PRECHARGE.
module sdram_write #(
  parameter logic [9:0] TRCD_CLK = 10'd2,
  parameter logic [9:0] TRP_CLK  = 10'd2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        wr_en,
  input  logic [20:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [9:0]  wr_burst_len,
  output logic        wr_ack,
  output logic        wr_end,
  output logic [3:0]  write_cmd,
  output logic [1:0]  write_ba,
  output logic [10:0] write_addr,
  output logic        wr_sdram_en,
  output logic [31:0] wr_sdram_data
);

  typedef enum logic [2:0] {
    W_IDLE, W_ACTIVE, W_TRCD, W_WRITE, W_DATA, W_PRE, W_TRP, W_END
  } state_t;

  localparam logic [3:0] CMD_NOP      = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE   = 4'b0011;
  localparam logic [3:0] CMD_WRITE    = 4'b0100;
  localparam logic [3:0] CMD_B_STOP   = 4'b0110;
  localparam logic [3:0] CMD_P_CHARGE = 4'b0010;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [20:0] addr_q, addr_d;
  logic [9:0]  len_m1_q, len_m1_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [10:0] saddr_q, saddr_d;
  logic        sdram_en_q, sdram_en_d;
  logic [9:0]  len_m1_in;
  logic        last_word;

  // Burst length is stored as L-1 after clamping to 1..256.
  always_comb begin
    if (wr_burst_len == 10'd0)
      len_m1_in = 10'd0;
    else if (wr_burst_len > 10'd256)
      len_m1_in = 10'd255;
    else
      len_m1_in = wr_burst_len - 10'd1;
  end

  assign last_word = (cnt_q == len_m1_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 10'd1;
    addr_d   = addr_q;
    len_m1_d = len_m1_q;
    cmd_d    = CMD_NOP;
    ba_d     = 2'b11;
    saddr_d  = 11'h7ff;
    wr_ack   = 1'b0;
    wr_end   = 1'b0;

    case (state_q)
      W_IDLE: begin
        if (wr_en && init_end) begin
          state_d  = W_ACTIVE;
          addr_d   = wr_addr;
          len_m1_d = len_m1_in;
        end
      end
      W_ACTIVE: begin
        state_d = W_TRCD;
        cmd_d   = CMD_ACTIVE;
        ba_d    = addr_q[20:19];
        saddr_d = addr_q[18:8];
      end
      W_TRCD: begin
        if (cnt_q + 10'd1 >= TRCD_CLK) state_d = W_WRITE;
      end
      W_WRITE: begin
        state_d = W_DATA;
        cmd_d   = CMD_WRITE;
        ba_d    = addr_q[20:19];
        saddr_d = {3'b000, addr_q[7:0]};
        wr_ack  = 1'b1;
      end
      W_DATA: begin
        if (last_word) begin
          state_d = W_PRE;
          cmd_d   = CMD_B_STOP;
        end else begin
          wr_ack  = 1'b1;
        end
      end
      W_PRE: begin
        state_d = W_TRP;
        cmd_d   = CMD_P_CHARGE;
        ba_d    = addr_q[20:19];
        saddr_d = 11'h400;
      end
      W_TRP: begin
        if (cnt_q + 10'd1 >= TRP_CLK) state_d = W_END;
      end
      W_END: begin
        wr_end  = 1'b1;
        state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase

    if (state_d != state_q) cnt_d = 10'd0;
    sdram_en_d = wr_ack;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= W_IDLE;
      cnt_q      <= 10'd0;
      addr_q     <= 21'd0;
      len_m1_q   <= 10'd0;
      cmd_q      <= CMD_NOP;
      ba_q       <= 2'b11;
      saddr_q    <= 11'h7ff;
      sdram_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      len_m1_q   <= len_m1_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      saddr_q    <= saddr_d;
      sdram_en_q <= sdram_en_d;
    end
  end

  assign write_cmd     = cmd_q;
  assign write_ba      = ba_q;
  assign write_addr    = saddr_q;
  assign wr_sdram_en   = sdram_en_q;
  assign wr_sdram_data = sdram_en_q ? wr_data : 32'd0;

endmodule

// File: tb/tb_sdram_write.sv
// tb/tb_sdram_write.sv - directed self-checking bench for sdram_write.
module tb_sdram_write;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] ACT  = 4'b0011;
  localparam logic [3:0] WR   = 4'b0100;
  localparam logic [3:0] BST  = 4'b0110;
  localparam logic [3:0] PCH  = 4'b0010;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic        wr_en;
  logic [20:0] wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  wr_burst_len;
  logic        wr_ack;
  logic        wr_end;
  logic [3:0]  write_cmd;
  logic [1:0]  write_ba;
  logic [10:0] write_addr;
  logic        wr_sdram_en;
  logic [31:0] wr_sdram_data;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_write dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .init_end      (init_end),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_burst_len  (wr_burst_len),
    .wr_ack        (wr_ack),
    .wr_end        (wr_end),
    .write_cmd     (write_cmd),
    .write_ba      (write_ba),
    .write_addr    (write_addr),
    .wr_sdram_en   (wr_sdram_en),
    .wr_sdram_data (wr_sdram_data)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_cmd"},  32'(write_cmd),     32'(NOP));
    check_eq({tag, "_ba"},   32'(write_ba),      32'h3);
    check_eq({tag, "_addr"}, 32'(write_addr),    32'h7ff);
    check_eq({tag, "_ack"},  32'(wr_ack),        32'h0);
    check_eq({tag, "_end"},  32'(wr_end),        32'h0);
    check_eq({tag, "_en"},   32'(wr_sdram_en),   32'h0);
    check_eq({tag, "_data"}, 32'(wr_sdram_data), 32'h0);
  endtask

  // Must be called #1 after a posedge with the DUT idle; that cycle is C0.
  task automatic run_burst(input string name, input logic [20:0] a, input logic [9:0] blen,
                           input int l, input logic [1:0] bank, input logic [10:0] row,
                           input logic [7:0] col, input bit perturb, input int rst_at);
    int       word_idx;
    bit       ack_prev;
    int       ack_cnt;
    logic [3:0]  e_cmd;
    logic [1:0]  e_ba;
    logic [10:0] e_ad;
    bit       chk_ba;
    bit       e_ack, e_en, e_end;
    int       e_data;
    string    t;
    word_idx     = 0;
    ack_prev     = 1'b0;
    ack_cnt      = 0;
    wr_addr      = a;
    wr_burst_len = blen;
    wr_data      = 32'hDEAD_BEEF;
    wr_en        = 1'b1;
    for (int c = 1; c <= 10 + l; c++) begin
      @(posedge sys_clk);
      #1;
      if (ack_prev) begin
        word_idx++;
        wr_data = 32'(word_idx);
      end
      if (c == 1) wr_en = 1'b0;
      if (perturb && c >= 2 && c <= 8) begin
        wr_en        = c[0];
        wr_addr      = ~a;
        wr_burst_len = 10'd7;
      end
      if (c == 9) wr_en = 1'b0;
      if (rst_at != 0 && c == rst_at + 1) begin
        sys_rst = 1'b0;
        #1;
        check_idle($sformatf("%s_rst_c%0d", name, c));
        return;
      end
      #1;
      e_cmd  = NOP; e_ba = 2'b11; e_ad = 11'h7ff; chk_ba = 1'b1;
      if (c == 2) begin
        e_cmd = ACT; e_ba = bank; e_ad = row;
      end else if (c == 5) begin
        e_cmd = WR; e_ba = bank; e_ad = {3'b000, col};
      end else if (c == 5 + l) begin
        e_cmd = BST; chk_ba = 1'b0;
      end else if (c == 6 + l) begin
        e_cmd = PCH; e_ba = bank; e_ad = 11'h400;
      end
      e_ack  = (c >= 4) && (c <= 3 + l);
      e_en   = (c >= 5) && (c <= 4 + l);
      e_data = e_en ? c - 4 : 0;
      e_end  = (c == 8 + l);
      t = $sformatf("%s_c%0d", name, c);
      check_eq({t, "_cmd"}, 32'(write_cmd), 32'(e_cmd));
      if (chk_ba) begin
        check_eq({t, "_ba"},   32'(write_ba),   32'(e_ba));
        check_eq({t, "_addr"}, 32'(write_addr), 32'(e_ad));
      end
      check_eq({t, "_ack"},  32'(wr_ack),        32'(e_ack));
      check_eq({t, "_en"},   32'(wr_sdram_en),   32'(e_en));
      check_eq({t, "_data"}, wr_sdram_data,      32'(e_data));
      check_eq({t, "_end"},  32'(wr_end),        32'(e_end));
      ack_prev = wr_ack;
      if (wr_ack) ack_cnt++;
      if (rst_at != 0 && c == rst_at) sys_rst = 1'b1;
    end
    check_eq({name, "_ack_count"}, 32'(ack_cnt), 32'(l));
  endtask

  initial begin
    sys_rst      = 1'b1;
    init_end     = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = 21'd0;
    wr_data      = 32'd0;
    wr_burst_len = 10'd0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    #1;
    check_idle("reset");

    wr_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk);
      #2;
      check_idle($sformatf("no_init_%0d", i));
    end
    wr_en    = 1'b0;
    init_end = 1'b1;
    @(posedge sys_clk);
    #1;

    run_burst("l4",   21'h1A_5F3C, 10'd4,   4,   2'b11, 11'h25F, 8'h3C, 1'b0, 0);
    run_burst("l1",   21'h0C_1234, 10'd1,   1,   2'b01, 11'h412, 8'h34, 1'b0, 0);
    run_burst("l0",   21'h0C_1234, 10'd0,   1,   2'b01, 11'h412, 8'h34, 1'b0, 0);
    run_burst("l300", 21'h10_0000, 10'd300, 256, 2'b10, 11'h000, 8'h00, 1'b0, 0);
    run_burst("pert", 21'h1A_5F3C, 10'd4,   4,   2'b11, 11'h25F, 8'h3C, 1'b1, 0);
    run_burst("rst",  21'h1A_5F3C, 10'd4,   4,   2'b11, 11'h25F, 8'h3C, 1'b0, 7);
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk);
      #2;
      check_idle($sformatf("post_rst_%0d", i));
    end
    @(posedge sys_clk);
    #1;
    run_burst("fresh", 21'h1A_5F3C, 10'd4,  4,   2'b11, 11'h25F, 8'h3C, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_write.md
# sdram_write

Write-burst engine for the SDRAM controller, the write-side counterpart of the read engine. On a granted write request after initialisation it opens the row (ACTIVE), issues a full-page WRITE, streams `wr_burst_len` 32-bit words from the upstream write FIFO, and terminates with BURST STOP. It then precharges the bank and pulses `wr_end`. Its command, bank and address outputs go to the controller's command arbiter.

## Interface
- `TRCD_CLK`, 10'd2, ACTIVE-to-WRITE wait in cycles.
- `TRP_CLK`, 10'd2, precharge wait in cycles.
- `sys_clk`  in  1  sole clock.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `init_end`  in  1  SDRAM initialisation complete.
- `wr_en`  in  1  write grant from arbiter; level, sampled in W_IDLE only.
- `wr_addr`  in  21  bank [20:19], row [18:8], start column [7:0].
- `wr_data`  in  32  FIFO read data, valid one cycle after each `wr_ack`.
- `wr_burst_len`  in  10  words per burst; 0 is treated as 1, values >256 clamp to 256.
- `wr_ack`  out  1  FIFO read strobe.
- `wr_end`  out  1  one-cycle burst-complete pulse.
- `write_cmd`  out  4  {CS_N,RAS_N,CAS_N,WE_N}.
- `write_ba`  out  2  bank address.
- `write_addr`  out  11  SDRAM address bus.
- `wr_sdram_en`  out  1  DQ output enable.
- `wr_sdram_data`  out  32  DQ write data.

## Operation
- Command encodings:
  - NOP 4'b0111
  - ACTIVE 4'b0011
  - WRITE 4'b0100
  - B_STOP 4'b0110
  - P_CHARGE 4'b0010
- States: W_IDLE, W_ACTIVE, W_TRCD, W_WRITE, W_DATA, W_PRE, W_TRP, W_END.
- Transitions:
  - W_IDLE → W_ACTIVE when `wr_en && init_end`. At this transition, latch `wr_addr` and the clamped burst length L.
  - W_ACTIVE → W_TRCD after 1 cycle.
  - W_TRCD → W_WRITE after TRCD_CLK cycles.
  - W_WRITE → W_DATA after 1 cycle.
  - W_DATA → W_PRE when cnt == L-1. For L=1 this is the first W_DATA cycle.
  - W_PRE → W_TRP after 1 cycle.
  - W_TRP → W_END after TRP_CLK cycles.
  - W_END → W_IDLE after 1 cycle.
- `cnt_clk` is 10 bits. It clears on every state transition and increments otherwise.
- Registered command outputs: `write_cmd`, `write_ba` and `write_addr` take their value from the state in the previous cycle. The default is NOP / 2'b11 / 11'h7ff.
  - W_ACTIVE: ACTIVE, bank, row.
  - W_WRITE: WRITE, bank, {3'b000, column}.
  - W_DATA at cnt == L-1: B_STOP (ba/addr don't care).
  - W_PRE: P_CHARGE, bank, 11'h400 (A10=1).
- `wr_ack` is combinational. It is high in W_WRITE and in W_DATA while cnt < L-1. It is therefore high for exactly L consecutive cycles.
- `wr_sdram_en` is `wr_ack` delayed one cycle (registered).
- `wr_sdram_data` = `wr_sdram_en ? wr_data : 32'd0`.
- Full-page burst. Column wrap within the row is the SDRAM's behaviour; the block does not split bursts.
- Write recovery: the last data word precedes P_CHARGE by 2 cycles.
- `wr_en` is ignored outside W_IDLE. `wr_addr` and `wr_burst_len` changes are ignored after latching.
- `init_end` low in W_IDLE holds W_IDLE regardless of `wr_en`.

## Timing
- Reset values (any cycle, including mid-burst): state W_IDLE, cnt 0, `write_cmd` NOP, `write_ba` 2'b11, `write_addr` 11'h7ff, `wr_ack`/`wr_end`/`wr_sdram_en` 0, `wr_sdram_data` 0. No B_STOP or precharge is issued on reset.
- Timeline with `wr_en` sampled high in cycle C0 and defaults TRCD_CLK = TRP_CLK = 2:
  - C1: W_ACTIVE.
  - C2: `write_cmd` = ACTIVE.
  - C4: W_WRITE.
  - `wr_ack`: C4 … C(3+L).
  - C5: `write_cmd` = WRITE, coincident with the first data word.
  - `wr_sdram_en`/data: C5 … C(4+L).
  - C(5+L): B_STOP on `write_cmd`.
  - C(6+L): P_CHARGE on `write_cmd`.
  - C(6+L+TRP_CLK): W_END, `wr_end` = 1.
- Back-to-back requests: the earliest next W_ACTIVE is 2 cycles after W_END (W_END → W_IDLE → W_ACTIVE).

## Test plan
- Reset, then `init_end`=0 with `wr_en`=1 for 20 cycles → stays W_IDLE; `write_cmd`=4'b0111, `write_ba`=2'b11, `write_addr`=11'h7ff; `wr_ack`=0.
- `wr_addr`=21'h1A_5F3C, L=4, FIFO data 1,2,3,4:
  - C2: ACTIVE, ba=2'b11, addr=11'h25F.
  - C5: WRITE, addr=11'h03C.
  - `wr_ack` C4–C7; data 1–4 on C5–C8 with en=1.
  - B_STOP C9; P_CHARGE C10, addr=11'h400.
  - `wr_end` C12 only.
- L=1 → exactly one `wr_ack` (C4) and one data cycle (C5); B_STOP C6; `wr_end` C9. L=0 gives the identical trace.
- L=300 → exactly 256 `wr_ack` cycles; B_STOP 256 cycles after the WRITE command.
- Change `wr_addr`/`wr_burst_len` and toggle `wr_en` mid-burst → outputs identical to the unperturbed run.
- Assert `sys_rst` in W_DATA at cnt=2 → next cycle all outputs at reset values. A fresh request afterwards completes normally.
